// File: rtl/mem_line_pkg.sv
// Shared constants, state encoding and address helper for the line responder.
package mem_line_pkg;

  localparam int LINE_BITS   = 1024;
  localparam int OFFSET_BITS = 7;
  localparam int ADDR_BITS   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef logic [LINE_BITS-1:0] line_t;

  // True when any address bit above the line index is set.
  function automatic logic addr_out_of_range(input logic [ADDR_BITS-1:0] addr,
                                             input int idx_bits);
    return (addr >> (OFFSET_BITS + idx_bits)) != '0;
  endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// Request/response handshake bundle between a cache (master) and the responder (slave).
interface mem_line_responder_if;
  import mem_line_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_BITS-1:0] req_addr;
  line_t                req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  line_t                resp_rdata;
  logic                 resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_line_store.sv
// Single-port line storage: one synchronous read/write access per enabled edge.
module mem_line_store
  import mem_line_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  line_t         wdata,
  output line_t         rdata
);

  line_t mem [DEPTH];

  // Write-through-old access: rdata returns the line as it was before any write on this edge.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency line fill/writeback responder: accept one request, wait LATENCY edges,
// access the line store, then hold the response until the cache consumes it.
module mem_line_responder
  import mem_line_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int NUM_LINES = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_line_responder_if.slave bus
);

  localparam int         IDX_W    = $clog2(NUM_LINES);
  localparam logic [1:0] IDLE     = ST_IDLE;
  localparam logic [1:0] BUSY     = ST_BUSY;
  localparam logic [1:0] RESP     = ST_RESP;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic             we_q;
  logic             oor_q;
  logic [IDX_W-1:0] idx_q;
  line_t            wdata_q;
  logic             rd_ok;
  logic             err_q;
  line_t            store_rdata;
  logic             accept;
  logic             done;
  logic             store_en;
  logic             unused_offset;

  // The byte offset within a line carries no information for a whole-line access.
  assign unused_offset = ^bus.req_addr[OFFSET_BITS-1:0];

  assign accept = (state == IDLE) && bus.req_valid;
  assign done   = (state == BUSY) && (cnt == 4'd0);
  // Reset on the completion edge aborts the access, so a pending write never lands.
  assign store_en = done && !oor_q && !rst;

  // Request capture; data path registers are left out of reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      oor_q   <= addr_out_of_range(bus.req_addr, IDX_W);
      idx_q   <= bus.req_addr[OFFSET_BITS +: IDX_W];
      wdata_q <= bus.req_wdata;
    end
  end

  // Control FSM with latency counter and response qualifiers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rd_ok <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
            rd_ok <= 1'b0;
            err_q <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            err_q <= oor_q;
            rd_ok <= !we_q && !oor_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_line_store #(
    .DEPTH (NUM_LINES),
    .AW    (IDX_W)
  ) u_store (
    .clk   (clk),
    .en    (store_en),
    .we    (we_q),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (store_rdata)
  );

  // Store output register is only exposed for successful reads; writes and errors return zero.
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rd_ok ? store_rdata : '0;

endmodule
